rrat_commit: RTL
================

# rrat_commit

Retirement-side register alias table and free-register return path. Accepts in-order commits from the ROB head, updates the architectural-to-physical map (`rrat_map`), and returns each superseded physical register to the rename free list one per cycle via `rrat_free`/`rrat_free_reg`. On a flushing commit it drains pending frees, then pulses the FRAT restore and pipeline flush. It is the return half of the rename free-list/RAT loop.

## Interface
Parameters:
- `FREE_DEPTH`, 4: depth of the internal free-return FIFO (power of two, ≥2).

Ports:
- `CLK`  in  1  clock; all state on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `STALL`  in  1  freezes all state, the FSM and the FIFO; outputs hold.
- `commit_valid`  in  1  ROB head is retiring this cycle.
- `commit_ready`  out  1  block accepts the commit; a commit is taken when valid & ready.
- `commit_regwr`  in  1  committing instruction writes a register (ALU write or load).
- `commit_arch_reg`  in  5  architectural destination.
- `commit_phys_reg`  in  6  physical register allocated at rename.
- `commit_is_flush`  in  1  commit triggers recovery (mispredict/exception).
- `rrat_map`  out  32×6  committed map, arch reg i → phys reg.
- `rrat_free`  out  1  `rrat_free_reg` is valid and returns to the free list this cycle.
- `rrat_free_reg`  out  6  freed physical register.
- `frat_restore`  out  1  one-cycle pulse: FRAT copies `rrat_map`.
- `flush_out`  out  1  one-cycle pulse, coincident with `frat_restore`.
- `committed_count`  out  32  accepted-commit counter.

## Operation
- Reset values: `rrat_map[i]=i`; FIFO empty; FSM `IDLE`; `commit_ready=0` while RESET high; `rrat_free=0`, `rrat_free_reg=0`, `frat_restore=0`, `flush_out=0`, `committed_count=0`. Phys regs 32–63 start in the free list, not here.
- `commit_ready = !STALL & state==IDLE & !fifo_full`.
- Accepted commit with `commit_regwr`, arch≠0: push old `rrat_map[arch]` into the FIFO; `rrat_map[arch] <= commit_phys_reg`.
- Accepted commit with `commit_regwr`, arch=0: map unchanged (stays 0); push `commit_phys_reg` so it is not leaked.
- Accepted commit without `commit_regwr`: no push, no map change.
- Every accepted commit increments `committed_count` (wraps modulo 2^32).
- Pop: each unstalled cycle, if the FIFO is non-empty, the head moves to `rrat_free_reg` with `rrat_free=1`; otherwise `rrat_free=0` and `rrat_free_reg` holds.
- FSM:
  - `IDLE` → `DRAIN` on an accepted commit with `commit_is_flush`. That commit's own map update and push still occur.
  - `DRAIN` (ready=0) → `RESTORE` when the FIFO is empty and no pop issues this cycle.
  - `RESTORE`: `frat_restore=1`, `flush_out=1` for one cycle, then → `IDLE`.
- Draining ensures no free arrives after the free list rebuilds from `rrat_map` on flush.
- Invariant: every accepted regwr commit yields exactly one `rrat_free` pulse.

## Timing
- Commit accepted at edge N: `rrat_map` is visible after N. Earliest `rrat_free` is the cycle after N+1 (push at N, pop at N+1). No bypass.
- Full FIFO: ready drops. A pop in that cycle frees a slot, and ready rises the next cycle. Push and pop in the same cycle keep occupancy unchanged.
- Flush commit at N with an empty FIFO and regwr: pop at N+1, `DRAIN` sees empty at N+2, `frat_restore` is high during the cycle after N+2, and `IDLE`/ready returns after N+3.
- `STALL` in `DRAIN`/`RESTORE`: state held; a `RESTORE` pulse is stretched until the first unstalled edge.
- RESET asserted mid-drain: immediate return to reset values; pending frees are discarded (the free list also resets).

## Structure
- Shared package `rat_pkg`: `NUM_ARCH=32`, `NUM_PHYS=64`, `AREG_W=5`, `PREG_W=6`, FSM enum `{IDLE, DRAIN, RESTORE}`.
- Sub-module `rrat_free_fifo` (`FREE_DEPTH`×6, push/pop, full/empty, occupancy counter one bit wider than the pointer).
- Map table and FSM live in `rrat_commit`.

## Test plan
- Reset then idle → `rrat_map[5]=5`, `rrat_free=0`, `commit_ready=1` after RESET falls.
- Commit regwr arch 5 → phys 40 → `rrat_map[5]=40` next cycle; one cycle later `rrat_free=1`, `rrat_free_reg=5`.
- Five back-to-back regwr commits with `STALL` high after the first three → ready drops while full and while stalled; exactly five frees in commit order; no loss or duplicate.
- Commit regwr arch 0 → phys 33 → `rrat_map[0]=0`; `rrat_free_reg=33`.
- Flush commit (regwr arch 3 → 50) with 2 frees queued → ready=0; three frees drain (including old phys 3); then a single cycle of `frat_restore=flush_out=1` with `rrat_map[3]=50`; ready returns next cycle.
- RESET pulse during `DRAIN` with 2 frees queued → all outputs at reset values, no `rrat_free` after release, `committed_count=0`.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared rename/retire constants and the retire FSM state type.
package rat_pkg;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int AREG_W   = 5;
  localparam int PREG_W   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RESTORE = 2'd2
  } rrat_state_e;
endpackage

// File: rtl/rrat_free_fifo.sv
// Free-return FIFO: holds superseded physical registers on their way back
// to the rename free list.
// Ports:
//   clk/rst        clock, async active-high reset
//   i_push/i_din   write one entry (caller guarantees !o_full)
//   i_pop          read one entry (caller guarantees !o_empty)
//   o_dout         head entry
//   o_full/o_empty occupancy flags
module rrat_free_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [PTR_W:0]          r_count;  // one wider than pointers so full is distinct

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop)
        r_rptr <= r_rptr + 1'b1;
      // Simultaneous push and pop leave occupancy unchanged.
      if (i_push && !i_pop)
        r_count <= r_count + 1'b1;
      else if (!i_push && i_pop)
        r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/rrat_commit.sv
// Retirement RAT: applies in-order commits to the architectural map and
// returns each superseded physical register to the free list, one per cycle.
// A flushing commit drains the free-return path, then pulses FRAT restore
// and pipeline flush together.
// Ports:
//   CLK/RESET/STALL   clock, async active-high reset, global freeze
//   commit_*          ROB-head commit handshake and payload
//   rrat_map          committed arch->phys map
//   rrat_free(_reg)   free-list return, one register per pulse
//   frat_restore      FRAT copies rrat_map (coincident with flush_out)
//   committed_count   accepted-commit counter (wraps)
import rat_pkg::*;

module rrat_commit #(
  parameter int FREE_DEPTH = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             STALL,
  input  logic                             commit_valid,
  output logic                             commit_ready,
  input  logic                             commit_regwr,
  input  logic [AREG_W-1:0]                commit_arch_reg,
  input  logic [PREG_W-1:0]                commit_phys_reg,
  input  logic                             commit_is_flush,
  output logic [NUM_ARCH-1:0][PREG_W-1:0]  rrat_map,
  output logic                             rrat_free,
  output logic [PREG_W-1:0]                rrat_free_reg,
  output logic                             frat_restore,
  output logic                             flush_out,
  output logic [31:0]                      committed_count
);
  rrat_state_e                     r_state;
  logic [NUM_ARCH-1:0][PREG_W-1:0] r_map;
  logic                            r_free;
  logic [PREG_W-1:0]               r_free_reg;
  logic                            r_restore;
  logic [31:0]                     r_count;

  logic              w_full, w_empty;
  logic              w_accept, w_push, w_pop;
  logic [PREG_W-1:0] w_push_data, w_head;

  assign commit_ready = !RESET && !STALL && (r_state == IDLE) && !w_full;
  assign w_accept     = commit_valid && commit_ready;
  assign w_push       = w_accept && commit_regwr;
  assign w_pop        = !STALL && !w_empty;
  // Arch reg 0 is hardwired to phys 0, so the newly allocated register is
  // the one that must go back, otherwise it would leak.
  assign w_push_data  = (commit_arch_reg == '0) ? commit_phys_reg
                                                : r_map[commit_arch_reg];

  rrat_free_fifo #(
    .DEPTH (FREE_DEPTH),
    .W     (PREG_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Map table, free-return output register and commit counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ARCH; i++)
        r_map[i] <= PREG_W'(i);
      r_free     <= 1'b0;
      r_free_reg <= '0;
      r_count    <= '0;
    end else if (!STALL) begin
      if (w_push && commit_arch_reg != '0)
        r_map[commit_arch_reg] <= commit_phys_reg;
      if (w_accept)
        r_count <= r_count + 32'd1;
      r_free <= w_pop;
      if (w_pop)
        r_free_reg <= w_head;
    end
  end

  // Flush sequencing. Restore waits until the last pending free has left
  // the FIFO so nothing returns after the free list rebuilds from the map.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_restore <= 1'b0;
    end else if (!STALL) begin
      case (r_state)
        IDLE: begin
          r_restore <= 1'b0;
          if (w_accept && commit_is_flush)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_empty && !w_pop) begin
            r_state   <= RESTORE;
            r_restore <= 1'b1;
          end
        end
        RESTORE: begin
          r_state   <= IDLE;
          r_restore <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_restore <= 1'b0;
        end
      endcase
    end
  end

  assign rrat_map        = r_map;
  assign rrat_free       = r_free;
  assign rrat_free_reg   = r_free_reg;
  assign frat_restore    = r_restore;
  assign flush_out       = r_restore;
  assign committed_count = r_count;
endmodule
